fifo_rd_scheduler: RTL
======================

// Module: fifo_rd_scheduler
// PURPOSE
//  Read-side scheduler for NUM_PORTS synchronous FIFOs, one per cache input port.
//  Drains them onto one shared output stream with valid/ready.
//  - Round-robin selects a non-empty FIFO and drives its rd_en.
//  - Captures dout one cycle later into a 2-entry output buffer.
//  - Tags each word with its source port.
//  Sits between the per-port input FIFOs and the shared cache write/lookup path.
// PARAMETERS
//  NUM_PORTS   4   number of FIFOs served (2..16)
//  DATA_WIDTH  8   FIFO word width; must match the FIFO DATA_WIDTH
//  BURST_LEN   4   max consecutive reads from one port (used only with FIFO_SCHED_BURST_EN)
// PORTS
//  clk         in   1                      single clock; all logic rising-edge
//  rst_n       in   1                      synchronous reset, active-low
//  fifo_dout   in   NUM_PORTS*DATA_WIDTH   per-FIFO dout; port i = bits [i*DW +: DW]
//  fifo_empty  in   NUM_PORTS              per-FIFO empty flag
//  fifo_rd_en  out  NUM_PORTS              per-FIFO read strobe; at most one bit set
//  out_data    out  DATA_WIDTH             scheduled word
//  out_port    out  $clog2(NUM_PORTS)      source FIFO index of out_data
//  out_valid   out  1                      out_data/out_port valid
//  out_ready   in   1                      downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - out_valid=0, out_data=0, out_port=0, buffer count=0, in-flight=0.
//   - RR pointer=0, burst counter=0.
//   - fifo_rd_en forced to 0 while rst_n=0.
//  FIFO timing: dout is valid the cycle after rd_en (registered-read FIFO).
//  Issue rule, evaluated every cycle:
//   - pop  = out_valid & out_ready
//   - room = (buf_cnt + inflight - pop) < 2
//   - If room and any ~fifo_empty: assert exactly one rd_en (the RR winner).
//   - rd_en is never asserted on an empty FIFO.
//  RR: search starts at the index after the last granted port and wraps NUM_PORTS-1 -> 0.
//  inflight: set in the cycle rd_en is asserted; the word is captured at the next edge.
//  Latency: rd_en at cycle t -> word in buffer, out_valid=1 at t+2 (buffer empty case).
//  Throughput: 1 word/cycle sustained with out_ready held high.
//  Buffer: 2-entry FIFO, in order. out_* show the head. Simultaneous capture+pop keeps count.
//  Backpressure:
//   - out_ready=0 -> buffer fills to 2 -> rd_en stops.
//   - No word is lost or duplicated.
//   - out_data/out_port held stable while out_valid & ~out_ready.
//  All FIFOs empty: no rd_en; out_valid drops once the buffer drains.
//  Reset mid-operation: the in-flight word and buffered words are discarded; the FIFOs are
//   reset by the same rst_n.
// CONFIGURATION
//  FIFO_SCHED_BURST_EN defined:
//   - The grant stays on a port while it is non-empty, for up to BURST_LEN reads.
//   - The pointer then advances. It also advances early when the port goes empty.
//  FIFO_SCHED_BURST_EN undefined: pointer advances after every read (pure per-word RR);
//   BURST_LEN is ignored and no burst counter is built.
// STRUCTURE
//  fifo_sched_pkg:
//   - port index typedef.
//   - OBUF_DEPTH=2 constant.
//   - function onehot2idx.
//  Sub-module rr_arbiter (NUM_PORTS): req, advance -> one-hot grant, grant_idx; holds the
//   pointer. Buffer, in-flight and burst logic live in fifo_rd_scheduler.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles with FIFOs non-empty -> rd_en=0, out_valid=0, out_data=0.
//  2 RR fairness:
//   - stimulus: all 4 FIFOs hold 3 words, out_ready=1, burst off.
//   - required: out_port sequence 0,1,2,3,0,1,2,3,...; 12 words in 12 consecutive cycles.
//  3 Sparse: only FIFO 2 non-empty (5 words) -> five words, all out_port=2; never rd_en[0,1,3].
//  4 Backpressure:
//   - stimulus: out_ready=0 for 10 cycles.
//   - required: exactly 2 reads issued, out_valid=1, out_data stable.
//   - then out_ready=1: order and values intact, no loss or duplication.
//  5 Burst (FIFO_SCHED_BURST_EN, BURST_LEN=4), FIFO0=6 words, FIFO1=2 words:
//   - required out_port order: 0,0,0,0,1,1,0,0.
//  6 Reset mid-stream (rst_n=0 while inflight=1 and buffer count=2):
//   - required: out_valid=0 on the next cycle, no stale word after release.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types, constants and helpers for the FIFO read scheduler.
// The optional burst mode is enabled by defining FIFO_SCHED_BURST_EN.
package fifo_sched_pkg;

    localparam int MAX_PORTS  = 16;
    localparam int OBUF_DEPTH = 2;

    typedef logic [3:0] port_idx_t;

    function automatic port_idx_t onehot2idx(input logic [MAX_PORTS-1:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rd_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr; advance moves ptr past the winner,
// stay parks ptr on the winner so it keeps priority.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    input  logic                 stay,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PW-1:0]        grant_idx
);

    logic [PW-1:0]        ptr;
    logic [PW:0]          sum;
    logic [PW-1:0]        idx;
    logic                 found;
    logic [MAX_PORTS-1:0] grant_wide;
    port_idx_t            idx_full;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        grant_wide                  = '0;
        grant_wide[NUM_PORTS-1:0]   = grant;
        idx_full                    = onehot2idx(grant_wide);
        grant_idx                   = idx_full[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + PW'(1);
        end else if (stay) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Drains NUM_PORTS registered-read FIFOs round-robin into a 2-entry tagged output buffer.
// Define FIFO_SCHED_BURST_EN to let a port keep the grant for up to BURST_LEN reads.
module fifo_rd_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    output logic [NUM_PORTS-1:0]            fifo_rd_en,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PW-1:0]                   out_port,
    output logic                            out_valid,
    input  logic                            out_ready
);

    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  grant;
    logic [PW-1:0]         grant_idx;
    logic                  pop;
    logic                  room;
    logic                  issue;
    logic                  advance;
    logic                  stay;
    logic [2:0]            occ;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic [PW-1:0]         inflight_port;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [DATA_WIDTH-1:0] buf_data [OBUF_DEPTH];
    logic [PW-1:0]         buf_port [OBUF_DEPTH];

    assign req       = ~fifo_empty;
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_data[0];
    assign out_port  = buf_port[0];
    assign pop       = out_valid & out_ready;

    // Words already buffered plus the one arriving, minus the one leaving, must leave a slot.
    assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign room  = (occ < 3'd2);
    assign issue = rst_n & room & (|req);

    assign fifo_rd_en = issue ? grant : '0;
    assign cap_data   = fifo_dout[inflight_port*DATA_WIDTH +: DATA_WIDTH];

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (advance),
        .stay      (stay),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef FIFO_SCHED_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_cnt_nxt;
    logic [PW-1:0] burst_port;
    logic          burst_end;

    // A burst restarts whenever the winner differs from the port being served.
    always_comb begin
        burst_cnt_nxt = BW'(1);
        if (burst_cnt != '0 && grant_idx == burst_port) burst_cnt_nxt = burst_cnt + BW'(1);
        burst_end = (burst_cnt_nxt == BW'(BURST_LEN));
        advance   = issue & burst_end;
        stay      = issue & ~burst_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt  <= '0;
            burst_port <= '0;
        end else if (issue) begin
            burst_cnt  <= burst_end ? '0 : burst_cnt_nxt;
            burst_port <= grant_idx;
        end
    end
`else
    assign advance = issue;
    assign stay    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_cnt       <= 2'd0;
            inflight      <= 1'b0;
            inflight_port <= '0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_port[0]   <= '0;
            buf_port[1]   <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_port <= grant_idx;

            case ({inflight, pop})
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf_data[0] <= buf_data[1];
                        buf_port[0] <= buf_port[1];
                        buf_data[1] <= cap_data;
                        buf_port[1] <= inflight_port;
                    end else begin
                        buf_data[0] <= cap_data;
                        buf_port[0] <= inflight_port;
                    end
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_port[0] <= buf_port[1];
                    buf_cnt     <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_data[0] <= cap_data;
                        buf_port[0] <= inflight_port;
                    end else begin
                        buf_data[1] <= cap_data;
                        buf_port[1] <= inflight_port;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
